// File: rtl/mix_columns_serial.sv
// rtl/mix_columns_serial.sv - byte-serial AES MixColumns stage between ShiftRows memory and AddRoundKey
// Reads one 4-byte column, then streams its 4 mixed (or bypassed) bytes.
module mix_columns_serial #(
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       last_round,
  input  logic [7:0] data_in,
  output logic       MIX_COL_start,
  output logic [3:0] MIX_COL_addr,
  output logic [7:0] out,
  output logic       out_valid,
  output logic [3:0] out_addr,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_col;
  logic [1:0] r_row;
  logic [1:0] r_wcnt;
  logic       r_bypass;
  logic [7:0] r_col_reg [4];
  logic       r_pipe_vld [RD_LATENCY];
  logic [1:0] r_pipe_row [RD_LATENCY];
  logic [7:0] w_mix [4];

  function automatic logic [7:0] xt2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] xt3(input logic [7:0] b);
    return xt2(b) ^ b;
  endfunction

  always_comb begin
    w_mix[0] = xt2(r_col_reg[0]) ^ xt3(r_col_reg[1]) ^ r_col_reg[2] ^ r_col_reg[3];
    w_mix[1] = r_col_reg[0] ^ xt2(r_col_reg[1]) ^ xt3(r_col_reg[2]) ^ r_col_reg[3];
    w_mix[2] = r_col_reg[0] ^ r_col_reg[1] ^ xt2(r_col_reg[2]) ^ xt3(r_col_reg[3]);
    w_mix[3] = xt3(r_col_reg[0]) ^ r_col_reg[1] ^ r_col_reg[2] ^ xt2(r_col_reg[3]);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_READ;
      S_READ:  if (r_row == 2'd3) w_next = S_WAIT;
      S_WAIT:  if (r_wcnt == 2'(RD_LATENCY - 1)) w_next = S_WRITE;
      S_WRITE: if (r_row == 2'd3) w_next = (r_col == 2'd3) ? S_DONE : S_READ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The strobe pipe carries the row of each issued read so the byte lands in the right slot on return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_col    <= '0;
      r_row    <= '0;
      r_wcnt   <= '0;
      r_bypass <= 1'b0;
      for (int i = 0; i < 4; i++) r_col_reg[i] <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_row[i] <= '0;
      end
    end else begin
      r_state       <= w_next;
      r_pipe_vld[0] <= (r_state == S_READ);
      r_pipe_row[0] <= r_row;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_row[i] <= r_pipe_row[i-1];
      end
      if (r_pipe_vld[RD_LATENCY-1]) r_col_reg[r_pipe_row[RD_LATENCY-1]] <= data_in;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bypass <= last_round;
            r_col    <= '0;
            r_row    <= '0;
          end
        end
        S_READ: begin
          r_row  <= r_row + 2'd1;
          r_wcnt <= '0;
        end
        S_WAIT:  r_wcnt <= r_wcnt + 2'd1;
        S_WRITE: begin
          r_row <= r_row + 2'd1;
          if (r_row == 2'd3) r_col <= r_col + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    MIX_COL_start = 1'b0;
    MIX_COL_addr  = '0;
    out           = '0;
    out_valid     = 1'b0;
    out_addr      = '0;
    done          = 1'b0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_READ: begin
        MIX_COL_start = 1'b1;
        MIX_COL_addr  = {r_col, r_row};
      end
      S_WAIT: begin
        MIX_COL_start = 1'b1;
        MIX_COL_addr  = {r_col, 2'd3};
      end
      S_WRITE: begin
        out_valid = 1'b1;
        out_addr  = {r_col, r_row};
        out       = r_bypass ? r_col_reg[r_row] : w_mix[r_row];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mix_columns_serial.sv
// tb/tb_mix_columns_serial.sv - bench for mix_columns_serial at read latency 1 and 2
// Both latencies run side by side from shared stimulus against a timeline reference model.
module tb_mix_columns_serial;

  logic       clk = 1'b0;
  logic       rst, start, last_round;
  logic [7:0] din1, din2, out1, out2;
  logic       sel1, sel2, ov1, ov2, busy1, busy2, done1, done2;
  logic [3:0] addr1, addr2, oa1, oa2;
  logic [19:0] o1, o2;

  always #5 clk = ~clk;

  mix_columns_serial #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .last_round(last_round), .data_in(din1),
    .MIX_COL_start(sel1), .MIX_COL_addr(addr1), .out(out1), .out_valid(ov1),
    .out_addr(oa1), .busy(busy1), .done(done1));

  mix_columns_serial #(.RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .last_round(last_round), .data_in(din2),
    .MIX_COL_start(sel2), .MIX_COL_addr(addr2), .out(out2), .out_valid(ov2),
    .out_addr(oa2), .busy(busy2), .done(done2));

  assign o1 = {busy1, done1, ov1, oa1, out1, sel1, addr1};
  assign o2 = {busy2, done2, ov2, oa2, out2, sel2, addr2};

  // State memory: garbage is returned whenever the read-select is low.
  logic [7:0] mem [16];
  logic [7:0] p1a, p2a, p2b;
  always @(posedge clk) begin
    p1a <= sel1 ? mem[addr1] : 8'($urandom);
    p2a <= sel2 ? mem[addr2] : 8'($urandom);
    p2b <= p2a;
  end
  assign din1 = p1a;
  assign din2 = p2b;

  int checks, failures;
  int cyc, st_cyc;
  int t0 [2];
  bit act [2];
  bit byp [2];
  logic [7:0] snap [2][16];
  logic [7:0] expm [2][16];
  logic [7:0] got  [2][16];
  bit fv [2];
  int lv [2], ld [2], dcnt [2];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, a, e);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++) if (m[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] mix_ref(input logic [31:0] col, input int r);
    logic [7:0] res = '0;
    logic [7:0] cf;
    for (int j = 0; j < 4; j++) begin
      case ((j - r) & 3)
        0: cf = 8'd2;
        1: cf = 8'd3;
        default: cf = 8'd1;
      endcase
      res ^= gmul(col[31-8*j -: 8], cf);
    end
    return res;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    return {mix_ref(col, 0), mix_ref(col, 1), mix_ref(col, 2), mix_ref(col, 3)};
  endfunction

  task automatic clear_rec();
    for (int d = 0; d < 2; d++) begin
      fv[d] = 0; lv[d] = -1; ld[d] = -1; dcnt[d] = 0;
      for (int i = 0; i < 16; i++) got[d][i] = '0;
    end
  endtask

  task automatic start_pass(input logic lr);
    @(posedge clk); #1 start = 1'b1; last_round = lr;
    @(posedge clk); #1 start = 1'b0; last_round = 1'($urandom);
    st_cyc = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy1 || busy2) && n < 200);
    chk("idle_timeout", {busy1, busy2}, 2'b00);
  endtask

  task automatic pass_checks();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("lat_valid_l%0d", d + 1), lv[d], 5 + d);
      chk($sformatf("lat_done_l%0d", d + 1), ld[d], 4 * (9 + d));
      chk($sformatf("done_count_l%0d", d + 1), dcnt[d], 1);
    end
  endtask

  task automatic got_checks(input string nm, input logic [127:0] e);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("%s_l%0d_col%0d", nm, d + 1, c),
            {got[d][4*c], got[d][4*c+1], got[d][4*c+2], got[d][4*c+3]}, e[127-32*c -: 32]);
  endtask

  task automatic load_mem(input logic [127:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v[127-8*i -: 8];
  endtask

  task automatic run_pass(input logic lr);
    clear_rec();
    start_pass(lr);
    wait_idle();
    pass_checks();
  endtask

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_c6c6c6c6_2d26314c;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_c6c6c6c6_4d7ebdf8;
  localparam logic [127:0] RAMP     = 128'h00010203_04050607_08090a0b_0c0d0e0f;

  initial begin
    rst = 1'b0; start = 1'b0; last_round = 1'b0;
    checks = 0; failures = 0; cyc = 0; st_cyc = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int d = 0; d < 2; d++) begin act[d] = 0; t0[d] = 0; byp[d] = 0; end
    clear_rec();

    fork
      forever begin : model
        int P;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
          P = 9 + d;
          if (!rst) act[d] = 0;
          else if (start && (!act[d] || (cyc - 1 - t0[d]) > 4 * P)) begin
            act[d] = 1; t0[d] = cyc; byp[d] = last_round;
            for (int i = 0; i < 16; i++) snap[d][i] = mem[i];
            for (int c = 0; c < 4; c++)
              for (int r = 0; r < 4; r++)
                expm[d][4*c+r] = mix_ref({mem[4*c], mem[4*c+1], mem[4*c+2], mem[4*c+3]}, r);
          end
        end
      end
      forever begin : compare
        int L, P, k, c, ph;
        logic eb, ed, ev, es;
        logic [3:0] eoa, ea;
        logic [7:0] eo;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          L = d + 1; P = 8 + L;
          eb = 0; ed = 0; ev = 0; es = 0; eoa = '0; ea = '0; eo = '0;
          if (rst && act[d]) begin
            k = cyc - t0[d];
            if (k < 4 * P) begin
              c = k / P; ph = k % P; eb = 1;
              if (ph < 4) begin es = 1; ea = 4'(4 * c + ph); end
              else if (ph < 4 + L) begin es = 1; ea = 4'(4 * c + 3); end
              else begin
                ev = 1; eoa = 4'(4 * c + ph - 4 - L);
                eo = byp[d] ? snap[d][eoa] : expm[d][eoa];
              end
            end else if (k == 4 * P) begin
              eb = 1; ed = 1;
            end
          end
          chk($sformatf("cycle_l%0d", L), (d == 0) ? o1 : o2, {eb, ed, ev, eoa, eo, es, ea});
          if (d == 0 ? ov1 : ov2) begin
            if (d == 0) got[0][oa1] = out1; else got[1][oa2] = out2;
            if (!fv[d]) begin fv[d] = 1; lv[d] = cyc - st_cyc; end
          end
          if (d == 0 ? done1 : done2) begin dcnt[d]++; ld[d] = cyc - st_cyc; end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {o1, o2}, 40'h0);
    @(posedge clk); #1 rst = 1'b1;

    chk("pin_model_fips", {mix_col(FIPS_IN[127:96]), mix_col(FIPS_IN[95:64])}, FIPS_OUT[127:64]);
    chk("pin_model_c2c3", {mix_col(FIPS_IN[63:32]), mix_col(FIPS_IN[31:0])}, FIPS_OUT[63:0]);

    load_mem(FIPS_IN);
    run_pass(1'b0);
    got_checks("fips", FIPS_OUT);

    load_mem(RAMP);
    run_pass(1'b1);
    got_checks("bypass", RAMP);

    // A start ten cycles into a pass must not disturb it.
    load_mem(FIPS_IN);
    clear_rec();
    start_pass(1'b0);
    repeat (9) @(posedge clk);
    #1 start = 1'b1; last_round = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    pass_checks();
    got_checks("restart_ignored", FIPS_OUT);

    // Start held in the DONE cycle of the latency-1 unit is ignored by both.
    clear_rec();
    start_pass(1'b0);
    for (int n = 0; n < 100 && !done1; n++) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    pass_checks();

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_pass(1'($urandom));
    end
    run_pass(1'b0);

    // Asynchronous reset during the third column's output phase.
    load_mem(FIPS_IN);
    clear_rec();
    start_pass(1'b0);
    for (int n = 0; n < 100 && !(ov1 && oa1[3:2] == 2'd2); n++) @(negedge clk);
    chk("reached_col2", {ov1, oa1[3:2]}, 3'b110);
    #1 rst = 1'b0;
    #1 chk("async_reset_zero", {o1, o2}, 40'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_reset", {dcnt[0], dcnt[1]}, 64'h0);
    run_pass(1'b0);
    got_checks("after_reset", FIPS_OUT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
